// File: rtl/sample_buffer_ctrl.sv
// Capture stage between the AtoD converter and an external 8-word RAM, used as a circular FIFO.
// Optional: define SAMPLE_BUFFER_OVERWRITE_OLDEST_EN to overwrite the oldest word when full.

module sample_buffer_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [ADDR_W-1:0] mem_address,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_oe
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

`ifdef SAMPLE_BUFFER_OVERWRITE_OLDEST_EN
  localparam bit OVERWRITE_EN = 1'b1;
`else
  localparam bit OVERWRITE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                rd_pending_q, rd_pending_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_oe_q, mem_oe_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  logic full_w;
  logic empty_w;
  logic accept;
  logic write_done;
  logic read_done;
  logic overwrite;

  assign full_w     = (count_q == DEPTH_CNT);
  assign empty_w    = (count_q == '0);
  assign accept     = sample_valid & ~hold_full_q;
  assign write_done = (state_q == S_WRITE);
  assign read_done  = (state_q == S_CAPTURE);
  // A write that starts while full can only exist when overwriting is enabled.
  assign overwrite  = write_done & full_w & OVERWRITE_EN;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (hold_full_q && (!full_w || OVERWRITE_EN)) begin
          state_d = S_WRITE;
        end else if (rd_pending_q && !empty_w) begin
          state_d = S_READ;
        end
      end
      S_WRITE:   state_d = S_IDLE;
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic, decoded from the next state and registered below
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we_d   = 1'b0;
    mem_oe_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    case (state_d)
      S_WRITE: begin
        mem_we_d   = 1'b1;
        mem_addr_d = wr_ptr_q;
      end
      S_READ: begin
        mem_oe_d   = 1'b1;
        mem_addr_d = rd_ptr_q;
      end
      S_CAPTURE: begin
        mem_oe_d   = 1'b1;
      end
      default: begin
        mem_we_d   = 1'b0;
        mem_oe_d   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: pointers, occupancy, hold register, read handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    rd_pending_d = rd_pending_q | rd_req;
    overflow_d   = overflow_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;

    if (accept) begin
      hold_d      = sample_in;
      hold_full_d = 1'b1;
    end
    if (sample_valid && hold_full_q) begin
      overflow_d = 1'b1;
    end

    if (write_done) begin
      wr_ptr_d    = wr_ptr_q + PTR_ONE;
      hold_full_d = 1'b0;
      if (overwrite) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        overflow_d = 1'b1;
      end else begin
        count_d    = count_q + CNT_ONE;
      end
    end

    // The RAM is still driving the bus during CAPTURE; latch it on the way out.
    if (read_done) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      count_d      = count_q - CNT_ONE;
      rd_pending_d = 1'b0;
      rd_data_d    = mem_data;
      rd_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      rd_pending_q <= 1'b0;
      overflow_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_oe_q     <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      rd_pending_q <= rd_pending_d;
      overflow_q   <= overflow_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      mem_we_q     <= mem_we_d;
      mem_oe_q     <= mem_oe_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_data     = mem_we_q ? hold_q : {DATA_W{1'bz}};
  assign mem_we       = mem_we_q;
  assign mem_oe       = mem_oe_q;
  assign mem_address  = mem_addr_q;
  assign sample_ready = ~hold_full_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign overflow     = overflow_q;

endmodule
